// File: rtl/controle_disparo.sv
// Battleship firing controller: latches a 5x7 map, classifies shots,
// tracks hit/shot bitmaps and counters, and declares victory or defeat.
// Ports: clk, reset (async, active-high), iniciar, mapa0..mapa4, linha,
//   coluna, disparar -> acertos0..4, tiros0..4, celulas_restantes,
//   tiros_restantes, estado, acertou, errou, repetido, invalido.
module controle_disparo #(
  parameter int MAX_TIROS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  input  logic [2:0] linha,
  input  logic [2:0] coluna,
  input  logic       disparar,
  output logic [6:0] acertos0,
  output logic [6:0] acertos1,
  output logic [6:0] acertos2,
  output logic [6:0] acertos3,
  output logic [6:0] acertos4,
  output logic [6:0] tiros0,
  output logic [6:0] tiros1,
  output logic [6:0] tiros2,
  output logic [6:0] tiros3,
  output logic [6:0] tiros4,
  output logic [5:0] celulas_restantes,
  output logic [5:0] tiros_restantes,
  output logic [1:0] estado,
  output logic       acertou,
  output logic       errou,
  output logic       repetido,
  output logic       invalido
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    JOGANDO = 2'b01,
    VITORIA = 2'b10,
    DERROTA = 2'b11
  } estado_t;

  estado_t     estado_q, estado_d;
  logic        ini_q, dis_q;
  logic [34:0] mapa_q, mapa_d;
  logic [34:0] acer_q, acer_d;
  logic [34:0] tiro_q, tiro_d;
  logic [5:0]  cel_q, cel_d;
  logic [5:0]  tir_q, tir_d;
  // {acertou, errou, repetido, invalido}
  logic [3:0]  pulso_q, pulso_d;

  logic [34:0] mapa_in;
  logic [5:0]  pop;
  logic [5:0]  idx;
  logic        ini_ev, dis_ev, fora;

  assign mapa_in = {mapa4, mapa3, mapa2, mapa1, mapa0};
  assign ini_ev  = iniciar & ~ini_q;
  assign dis_ev  = disparar & ~dis_q;
  assign fora    = (linha > 3'd4) || (coluna > 3'd6);
  // Row r occupies bits [7r+6:7r]; column c maps to bit 6-c of its row.
  assign idx     = 6'(linha) * 6'd7 + 6'd6 - 6'(coluna);

  always_comb begin
    pop = '0;
    for (int i = 0; i < 35; i++)
      pop = pop + 6'(mapa_in[i]);
  end

  always_comb begin
    estado_d = estado_q;
    mapa_d   = mapa_q;
    acer_d   = acer_q;
    tiro_d   = tiro_q;
    cel_d    = cel_q;
    tir_d    = tir_q;
    pulso_d  = 4'b0000;
    if (ini_ev) begin
      // A restart swallows any shot edge arriving in the same cycle.
      mapa_d   = mapa_in;
      acer_d   = '0;
      tiro_d   = '0;
      cel_d    = pop;
      tir_d    = 6'(MAX_TIROS);
      estado_d = (pop == 6'd0) ? VITORIA : JOGANDO;
    end else if (dis_ev && estado_q == JOGANDO) begin
      if (fora) begin
        pulso_d = 4'b0001;
      end else if (tiro_q[idx]) begin
        pulso_d = 4'b0010;
      end else begin
        tiro_d[idx] = 1'b1;
        tir_d       = tir_q - 6'd1;
        if (mapa_q[idx]) begin
          acer_d[idx] = 1'b1;
          cel_d       = cel_q - 6'd1;
          pulso_d     = 4'b1000;
        end else begin
          pulso_d = 4'b0100;
        end
        // Sinking the last ship on the last shot counts as a win.
        if (cel_d == 6'd0)
          estado_d = VITORIA;
        else if (tir_d == 6'd0)
          estado_d = DERROTA;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= IDLE;
      ini_q    <= 1'b0;
      dis_q    <= 1'b0;
      mapa_q   <= '0;
      acer_q   <= '0;
      tiro_q   <= '0;
      cel_q    <= '0;
      tir_q    <= '0;
      pulso_q  <= '0;
    end else begin
      estado_q <= estado_d;
      ini_q    <= iniciar;
      dis_q    <= disparar;
      mapa_q   <= mapa_d;
      acer_q   <= acer_d;
      tiro_q   <= tiro_d;
      cel_q    <= cel_d;
      tir_q    <= tir_d;
      pulso_q  <= pulso_d;
    end
  end

  assign acertos0 = acer_q[6:0];
  assign acertos1 = acer_q[13:7];
  assign acertos2 = acer_q[20:14];
  assign acertos3 = acer_q[27:21];
  assign acertos4 = acer_q[34:28];
  assign tiros0   = tiro_q[6:0];
  assign tiros1   = tiro_q[13:7];
  assign tiros2   = tiro_q[20:14];
  assign tiros3   = tiro_q[27:21];
  assign tiros4   = tiro_q[34:28];

  assign celulas_restantes = cel_q;
  assign tiros_restantes   = tir_q;
  assign estado            = estado_q;
  assign acertou           = pulso_q[3];
  assign errou             = pulso_q[2];
  assign repetido          = pulso_q[1];
  assign invalido          = pulso_q[0];

endmodule

// File: tb/tb_controle_disparo.sv
// Self-checking bench for controle_disparo: directed vector table plus
// hand-written multi-cycle sequences (restart, defeat, victory, reset).
module tb_controle_disparo;

  logic       clk, reset, iniciar, disparar;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
  logic [2:0] linha, coluna;

  logic [6:0] acertos0, acertos1, acertos2, acertos3, acertos4;
  logic [6:0] tiros0, tiros1, tiros2, tiros3, tiros4;
  logic [5:0] cel, tir;
  logic [1:0] estado;
  logic       acertou, errou, repetido, invalido;

  logic [6:0] b_ac0, b_ac1, b_ac2, b_ac3, b_ac4;
  logic [6:0] b_ti0, b_ti1, b_ti2, b_ti3, b_ti4;
  logic [5:0] b_cel, b_tir;
  logic [1:0] b_est;
  logic       b_ac, b_er, b_rep, b_inv;

  int errors = 0;
  int checks = 0;

  controle_disparo #(.MAX_TIROS(15)) u0 (
    .clk(clk), .reset(reset), .iniciar(iniciar),
    .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2),
    .mapa3(mapa3), .mapa4(mapa4),
    .linha(linha), .coluna(coluna), .disparar(disparar),
    .acertos0(acertos0), .acertos1(acertos1), .acertos2(acertos2),
    .acertos3(acertos3), .acertos4(acertos4),
    .tiros0(tiros0), .tiros1(tiros1), .tiros2(tiros2),
    .tiros3(tiros3), .tiros4(tiros4),
    .celulas_restantes(cel), .tiros_restantes(tir), .estado(estado),
    .acertou(acertou), .errou(errou),
    .repetido(repetido), .invalido(invalido)
  );

  controle_disparo #(.MAX_TIROS(1)) u1 (
    .clk(clk), .reset(reset), .iniciar(iniciar),
    .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2),
    .mapa3(mapa3), .mapa4(mapa4),
    .linha(linha), .coluna(coluna), .disparar(disparar),
    .acertos0(b_ac0), .acertos1(b_ac1), .acertos2(b_ac2),
    .acertos3(b_ac3), .acertos4(b_ac4),
    .tiros0(b_ti0), .tiros1(b_ti1), .tiros2(b_ti2),
    .tiros3(b_ti3), .tiros4(b_ti4),
    .celulas_restantes(b_cel), .tiros_restantes(b_tir), .estado(b_est),
    .acertou(b_ac), .errou(b_er),
    .repetido(b_rep), .invalido(b_inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run still active at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] l;
    logic [2:0] c;
    logic [3:0] p;
    int         cel;
    int         tir;
    int         est;
  } vec_t;

  vec_t tab[7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] pa();
    return {acertou, errou, repetido, invalido};
  endfunction

  function automatic logic [3:0] pb();
    return {b_ac, b_er, b_rep, b_inv};
  endfunction

  task automatic set_map(input logic [6:0] a, b, c, d, e);
    mapa0 = a; mapa1 = b; mapa2 = c; mapa3 = d; mapa4 = e;
  endtask

  task automatic start();
    @(negedge clk) iniciar = 1'b1;
    @(posedge clk); #1;
    @(negedge clk) iniciar = 1'b0;
    @(posedge clk); #1;
  endtask

  // Fire one shot; returns the pulse vectors seen right after the edge.
  task automatic fire(input logic [2:0] l, input logic [2:0] c,
                      output logic [3:0] p, output logic [3:0] q);
    @(negedge clk);
    linha = l; coluna = c; disparar = 1'b1;
    @(posedge clk); #1;
    p = pa();
    q = pb();
    @(negedge clk) disparar = 1'b0;
    @(posedge clk); #1;
    chk("pulse_drop", int'(pa()), 0);
  endtask

  logic [3:0] p, q;
  int ml[15] = '{0,0,0,0,0,0,1,1,1,1,1,2,2,2,2};
  int mc[15] = '{0,1,2,3,5,6,0,1,2,5,6,1,2,3,5};
  int hits;

  initial begin
    tab[0] = '{3'd0, 3'd4, 4'b1000, 12, 14, 1};
    tab[1] = '{3'd0, 3'd0, 4'b0100, 12, 13, 1};
    tab[2] = '{3'd0, 3'd4, 4'b0010, 12, 13, 1};
    tab[3] = '{3'd5, 3'd0, 4'b0001, 12, 13, 1};
    tab[4] = '{3'd0, 3'd7, 4'b0001, 12, 13, 1};
    tab[5] = '{3'd1, 3'd3, 4'b1000, 11, 12, 1};
    tab[6] = '{3'd2, 3'd1, 4'b0100, 11, 11, 1};

    reset = 1'b1; iniciar = 1'b0; disparar = 1'b0;
    linha = '0; coluna = '0;
    set_map(7'b0000100, 7'b0001100, 7'b1000101, 7'b1110001, 7'b1000011);
    #12;
    chk("rst_estado", int'(estado), 0);
    chk("rst_cel", int'(cel), 0);
    chk("rst_tir", int'(tir), 0);
    chk("rst_pulses", int'(pa()), 0);
    @(negedge clk) reset = 1'b0;

    // Start game
    start();
    chk("start_estado", int'(estado), 1);
    chk("start_cel", int'(cel), 13);
    chk("start_tir", int'(tir), 15);
    chk("start_bitmaps", int'(|{acertos0, acertos1, acertos2, acertos3,
        acertos4, tiros0, tiros1, tiros2, tiros3, tiros4}), 0);

    // Latched copy only: clobbering the inputs must not matter
    set_map('0, '0, '0, '0, '0);

    for (int i = 0; i < 7; i++) begin
      fire(tab[i].l, tab[i].c, p, q);
      chk($sformatf("vec%0d_pulse", i), int'(p), int'(tab[i].p));
      chk($sformatf("vec%0d_cel", i), int'(cel), tab[i].cel);
      chk($sformatf("vec%0d_tir", i), int'(tir), tab[i].tir);
      chk($sformatf("vec%0d_est", i), int'(estado), tab[i].est);
    end
    chk("acertos0", int'(acertos0), int'(7'b0000100));
    chk("tiros0", int'(tiros0), int'(7'b1000100));
    chk("acertos1", int'(acertos1), int'(7'b0001000));
    chk("tiros1", int'(tiros1), int'(7'b0001000));
    chk("tiros2", int'(tiros2), int'(7'b0100000));

    // Held disparar counts once
    hits = 0;
    @(negedge clk);
    linha = 3'd4; coluna = 3'd5; disparar = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      hits += int'(acertou);
    end
    @(negedge clk) disparar = 1'b0;
    @(posedge clk); #1;
    chk("hold_hits", hits, 1);
    chk("hold_cel", int'(cel), 10);
    chk("hold_tir", int'(tir), 10);
    chk("hold_acertos4", int'(acertos4), int'(7'b0000010));

    // Restart mid-game, then run out of shots
    set_map(7'b0000100, 7'b0001100, 7'b1000101, 7'b1110001, 7'b1000011);
    start();
    chk("restart_cel", int'(cel), 13);
    chk("restart_tir", int'(tir), 15);
    chk("restart_bitmaps", int'(|{acertos4, tiros0, tiros1, tiros2, tiros4}), 0);
    for (int i = 0; i < 15; i++) begin
      fire(3'(ml[i]), 3'(mc[i]), p, q);
      chk($sformatf("miss%0d_pulse", i), int'(p), int'(4'b0100));
      chk($sformatf("miss%0d_tir", i), int'(tir), 14 - i);
      chk($sformatf("miss%0d_est", i), int'(estado), (i == 14) ? 3 : 1);
    end
    chk("lose_cel", int'(cel), 13);
    fire(3'd0, 3'd4, p, q);
    chk("lost_ignore_pulse", int'(p), 0);
    chk("lost_ignore_est", int'(estado), 3);
    chk("lost_ignore_acertos0", int'(acertos0), 0);
    start();
    chk("replay_est", int'(estado), 1);
    chk("replay_cel", int'(cel), 13);
    chk("replay_tir", int'(tir), 15);

    // Single-cell map, one shot: victory beats defeat
    set_map('0, '0, '0, '0, 7'b0000001);
    start();
    chk("one_est_b", int'(b_est), 1);
    chk("one_cel_b", int'(b_cel), 1);
    chk("one_tir_b", int'(b_tir), 1);
    fire(3'd4, 3'd6, p, q);
    chk("one_pulse_b", int'(q), int'(4'b1000));
    chk("one_est_b_win", int'(b_est), 2);
    chk("one_cel_b_win", int'(b_cel), 0);
    chk("one_tir_b_win", int'(b_tir), 0);
    chk("one_est_a_win", int'(estado), 2);
    chk("one_tir_a", int'(tir), 14);

    // Empty map: instant victory
    set_map('0, '0, '0, '0, '0);
    start();
    chk("empty_est", int'(estado), 2);
    chk("empty_cel", int'(cel), 0);
    chk("empty_tir", int'(tir), 15);

    // Asynchronous reset mid-game clears a pending pulse
    set_map(7'b0000100, 7'b0001100, 7'b1000101, 7'b1110001, 7'b1000011);
    start();
    @(negedge clk);
    linha = 3'd0; coluna = 3'd4; disparar = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_acertou", int'(acertou), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_estado", int'(estado), 0);
    chk("arst_cel", int'(cel), 0);
    chk("arst_tir", int'(tir), 0);
    chk("arst_pulses", int'(pa()), 0);
    chk("arst_bitmaps", int'(|{acertos0, tiros0}), 0);
    @(negedge clk);
    reset = 1'b0; disparar = 1'b0;

    // Simultaneous iniciar and disparar: restart only
    start();
    fire(3'd0, 3'd4, p, q);
    chk("sim_pre_pulse", int'(p), int'(4'b1000));
    @(negedge clk);
    iniciar = 1'b1; disparar = 1'b1; linha = 3'd0; coluna = 3'd0;
    @(posedge clk); #1;
    chk("sim_pulse", int'(pa()), 0);
    chk("sim_est", int'(estado), 1);
    chk("sim_cel", int'(cel), 13);
    chk("sim_tir", int'(tir), 15);
    chk("sim_tiros0", int'(tiros0), 0);
    @(negedge clk);
    iniciar = 1'b0; disparar = 1'b0;
    @(posedge clk); #1;
    chk("sim_after_pulse", int'(pa()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
